// File: rtl/gpr_file_mp.sv
// Multi-ported general-purpose register file for the dual-issue core.
// NRD combinational read ports, NWR synchronous write ports, optional
// same-cycle write->read forwarding, optional hardwired-zero r0, and a
// hardware clear sweep after reset or on request that gates use via 'ready'.
module gpr_file_mp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NRD        = 4,
    parameter int NWR        = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_R0    = 1,
    parameter int INIT_SWEEP = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   init_req,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*ADDR_W-1:0]  wr_addr,
    input  logic [NWR*DATA_W-1:0]  wr_data,
    output logic                   ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   clr_ptr_r;
    logic [ADDR_W-1:0]   clr_ptr_s;
    logic                clr_en_s;
    logic                wr_ok_s;
    logic                rd_ok_s;
    logic                ready_r;
    logic [DATA_W-1:0]   gpr_r [DEPTH];
    logic [NRD*DATA_W-1:0] rd_data_s;

    // Next-state logic: reset picks the start state, CLEAR walks the sweep pointer, READY accepts writes.
    always_comb begin
        state_s   = state_r;
        clr_ptr_s = clr_ptr_r;
        clr_en_s  = 1'b0;
        wr_ok_s   = 1'b0;
        if (!resetn) begin
            state_s   = (INIT_SWEEP != 0) ? ST_CLEAR : ST_READY;
            clr_ptr_s = '0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_en_s = 1'b1;
                    if (clr_ptr_r == ADDR_W'(DEPTH - 1)) begin
                        state_s   = ST_READY;
                        clr_ptr_s = '0;
                    end else begin
                        clr_ptr_s = clr_ptr_r + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    wr_ok_s = 1'b1;
                    if (init_req && (INIT_SWEEP != 0)) begin
                        state_s   = ST_CLEAR;
                        clr_ptr_s = '0;
                    end else begin
                        state_s   = ST_READY;
                    end
                end
                default: begin
                    state_s   = (INIT_SWEEP != 0) ? ST_CLEAR : ST_READY;
                    clr_ptr_s = '0;
                end
            endcase
        end
    end

    // State, sweep pointer and registered ready flag (low whenever reset is sampled).
    always_ff @(posedge clk) begin
        state_r   <= state_s;
        clr_ptr_r <= clr_ptr_s;
        ready_r   <= resetn && (state_s == ST_READY);
    end

    // Storage update: the sweep zeroes one entry per cycle; otherwise commit writes, later ports override earlier ones.
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            gpr_r[clr_ptr_r] <= '0;
        end else if (wr_ok_s) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && !((ZERO_R0 != 0) && (wr_addr[p*ADDR_W +: ADDR_W] == '0))) begin
                    gpr_r[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign rd_ok_s = ready_r && resetn;

    // Read ports: stored value, optionally overridden by the highest matching write port, forced to zero for r0 or when not ready.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data_s[i*DATA_W +: DATA_W] = gpr_r[rd_addr[i*ADDR_W +: ADDR_W]];
            for (int p = 0; p < NWR; p++) begin
                rd_data_s[i*DATA_W +: DATA_W] =
                    ((BYPASS != 0) && wr_ok_s && wr_en[p] &&
                     (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]))
                    ? wr_data[p*DATA_W +: DATA_W] : rd_data_s[i*DATA_W +: DATA_W];
            end
            if (!rd_ok_s || ((ZERO_R0 != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0))) begin
                rd_data_s[i*DATA_W +: DATA_W] = '0;
            end else begin
                rd_data_s[i*DATA_W +: DATA_W] = rd_data_s[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_data = rd_data_s;
    assign ready   = ready_r;

endmodule
